// File: rtl/rx78_pixel_pipe.sv
// rx78_pixel_pipe: VRAM video fetch, six plane shifters, palette resolve.
// Optional macro RX78_CMASK_EN applies cmask to the fg/bg indices.
module rx78_pixel_pipe #(
   parameter logic [8:0] H_START    = 9'd64,
   parameter logic [8:0] V_START    = 9'd16,
   parameter int         LINE_BYTES = 24,
   parameter int         V_LINES    = 184
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_pix,
   input  logic [8:0]  h,
   input  logic [8:0]  v,
   input  logic [7:0]  fg1,
   input  logic [7:0]  fg2,
   input  logic [7:0]  fg3,
   input  logic [7:0]  bg1,
   input  logic [7:0]  bg2,
   input  logic [7:0]  bg3,
   input  logic [7:0]  p1,
   input  logic [7:0]  p2,
   input  logic [7:0]  p3,
   input  logic [7:0]  p4,
   input  logic [7:0]  p5,
   input  logic [7:0]  p6,
   input  logic [7:0]  mask,
   input  logic [5:0]  cmask,
   input  logic [7:0]  bgc,
   output logic [12:0] vdp_addr,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        de
);

   localparam int BW = $clog2(LINE_BYTES + 1);
   localparam logic [9:0] H_PRE = 10'(H_START) - 10'd2;
   localparam logic [9:0] H_LD0 = 10'(H_START) - 10'd1;
   localparam logic [9:0] H_LO  = 10'(H_START);
   localparam logic [9:0] H_HI  = 10'(H_START) + 10'(8 * LINE_BYTES);
   localparam logic [9:0] V_LO  = 10'(V_START);
   localparam logic [9:0] V_HI  = 10'(V_START) + 10'(V_LINES);
   localparam logic [BW-1:0] BC_LAST = BW'(LINE_BYTES - 1);

   typedef enum logic {IDLE, FETCH} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   bc;
   logic [8:0]      v_fetch;
   logic [5:0][7:0] sr;
   logic [9:0]      h10, v10, ld_h;
   logic [8:0]      row;
   logic [12:0]     base;
   logic            active_line, active_pix, in_win;
   logic            start, load;
   logic [2:0]      fi, bi, col, pix_col;
   logic            bits_unused;

   assign h10 = {1'b0, h};
   assign v10 = {1'b0, v};
   assign active_line = (v10 >= V_LO) && (v10 < V_HI);
   assign active_pix  = active_line && (h10 >= H_LO) && (h10 < H_HI);
   assign in_win      = (h10 >= H_PRE) && (h10 < H_HI);
   assign row  = v - V_START;
   assign base = {row, 4'b0000} + 13'({row, 3'b000});
   assign ld_h = H_LD0 + 10'({bc, 3'b000});
   assign bits_unused = ^{mask[7:6], bgc[7:3]};

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      start   = active_line && (h10 == H_PRE);
      if (start) begin
         state_d = FETCH;
      end else if (state_q == FETCH) begin
         // a v change or leaving the window abandons the line's fetch
         if ((v != v_fetch) || !in_win) begin
            state_d = IDLE;
         end else if (h10 == ld_h) begin
            load = 1'b1;
            if (bc == BC_LAST) state_d = IDLE;
         end
      end
   end

`ifdef RX78_CMASK_EN
   assign fi = {sr[2][0], sr[1][0], sr[0][0]} & mask[2:0] & cmask[2:0];
   assign bi = {sr[5][0], sr[4][0], sr[3][0]} & mask[5:3] & cmask[5:3];
`else
   logic cmask_unused;
   assign cmask_unused = ^cmask;
   assign fi = {sr[2][0], sr[1][0], sr[0][0]} & mask[2:0];
   assign bi = {sr[5][0], sr[4][0], sr[3][0]} & mask[5:3];
`endif

   always_comb begin
      col = bgc[2:0];
      if (fi != 3'd0)      col = {p3[fi], p2[fi], p1[fi]};
      else if (bi != 3'd0) col = {p6[bi], p5[bi], p4[bi]};
   end

   assign pix_col = active_pix ? col : bgc[2:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         bc       <= '0;
         v_fetch  <= '0;
         vdp_addr <= '0;
         sr       <= '0;
         red      <= '0;
         green    <= '0;
         blue     <= '0;
         de       <= 1'b0;
      end else if (ce_pix) begin
         state_q <= state_d;
         if (start) begin
            vdp_addr <= base;
            bc       <= '0;
            v_fetch  <= v;
         end else if (load) begin
            vdp_addr <= vdp_addr + 13'd1;
            bc       <= bc + BW'(1);
         end
         if (load) begin
            sr <= {bg3, bg2, bg1, fg3, fg2, fg1};
         end else if (active_pix) begin
            for (int i = 0; i < 6; i++) sr[i] <= sr[i] >> 1;
         end
         de    <= active_pix;
         red   <= {8{pix_col[0]}};
         green <= {8{pix_col[1]}};
         blue  <= {8{pix_col[2]}};
      end
   end

endmodule

// File: tb/tb_rx78_pixel_pipe.sv
// Directed bench for rx78_pixel_pipe: fetch addresses, pixel colours,
// mask/cmask behaviour and mid-line reset recovery.
module tb_rx78_pixel_pipe;

   logic        clk = 1'b0;
   logic        reset, ce_pix;
   logic [8:0]  h, v;
   logic [7:0]  fg1, fg2, fg3, bg1, bg2, bg3;
   logic [7:0]  p1, p2, p3, p4, p5, p6;
   logic [7:0]  mask, bgc;
   logic [5:0]  cmask;
   logic [12:0] vdp_addr;
   logic [7:0]  red, green, blue;
   logic        de;

   int total = 0;
   int passed = 0;
   int fails = 0;
   int ea;

   rx78_pixel_pipe dut (
      .clk(clk), .reset(reset), .ce_pix(ce_pix), .h(h), .v(v),
      .fg1(fg1), .fg2(fg2), .fg3(fg3), .bg1(bg1), .bg2(bg2), .bg3(bg3),
      .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6),
      .mask(mask), .cmask(cmask), .bgc(bgc),
      .vdp_addr(vdp_addr), .red(red), .green(green), .blue(blue), .de(de)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one ce_pix pulse followed by one idle clk; returns at a negedge
   task automatic step(input int hh, input int vv);
      h = 9'(hh);
      v = 9'(vv);
      ce_pix = 1'b1;
      @(negedge clk);
      ce_pix = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; ce_pix = 1'b0; h = '0; v = '0;
      {fg1, fg2, fg3, bg1, bg2, bg3} = '0;
      {p1, p2, p3, p4, p5, p6} = '0;
      mask = 8'h3F; cmask = 6'h3F; bgc = 8'h05;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_addr", 32'(vdp_addr), 32'd0);
      chk("rst_rgb", 32'({red, green, blue}), 32'h0);
      chk("rst_de", 32'(de), 32'd0);

      step(100, 0);
      chk("border_rgb", 32'({red, green, blue}), 32'hFF00FF);
      chk("border_de", 32'(de), 32'd0);

      // address sequence on line row 2
      for (int x = 62; x < 300; x++) begin
         step(x, 18);
         if (x == 62) ea = 48;
         else ea = 48 + (((x - 63) / 8 + 1) > 24 ? 24 : ((x - 63) / 8 + 1));
         chk("addr", 32'(vdp_addr), 32'(ea));
         chk("de", 32'(de), 32'((x >= 64 && x < 256) ? 1 : 0));
         chk("blank_rgb", 32'({red, green, blue}), 32'hFF00FF);
      end

      // single fg1 pixel through p1
      fg1 = 8'h01; p1 = 8'h02; bgc = 8'h04;
      step(62, 19);
      chk("row3_base", 32'(vdp_addr), 32'd72);
      step(63, 19);
      for (int x = 0; x < 8; x++) begin
         step(64 + x, 19);
         chk("fg1_pix", 32'({red, green, blue}),
             (x == 0) ? 32'hFF0000 : 32'h0000FF);
      end

      // background plane 2, then masked off
      fg1 = 8'h00; p1 = 8'h00; bg2 = 8'hFF; p5 = 8'h04;
      step(62, 20);
      step(63, 20);
      for (int x = 0; x < 8; x++) begin
         step(64 + x, 20);
         chk("bg2_pix", 32'({red, green, blue}), 32'h00FF00);
      end
      mask = 8'h07;
      for (int x = 8; x < 16; x++) begin
         step(64 + x, 20);
         chk("bg_masked", 32'({red, green, blue}), 32'h0000FF);
      end

      // fg3 against cmask
      bg2 = 8'h00; p5 = 8'h00; mask = 8'h3F;
      fg3 = 8'hFF; cmask = 6'h03; p1 = 8'h10; p3 = 8'h10;
      step(62, 21);
      step(63, 21);
      for (int x = 0; x < 8; x++) begin
         step(64 + x, 21);
`ifdef RX78_CMASK_EN
         chk("cmask_pix", 32'({red, green, blue}), 32'h0000FF);
`else
         chk("cmask_pix", 32'({red, green, blue}), 32'hFF00FF);
`endif
      end

      // reset in mid-line, then the next line's fetch
      fg3 = 8'h00; cmask = 6'h3F; fg1 = 8'hFF; p1 = 8'h02; p3 = 8'h00;
      for (int x = 62; x < 114; x++) begin
         step(x, 22);
         if (x >= 64) chk("pre_rst_pix", 32'({red, green, blue}), 32'hFF0000);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_addr", 32'(vdp_addr), 32'd0);
      chk("mid_rst_rgb", 32'({red, green, blue}), 32'h0);
      for (int x = 114; x < 260; x++) begin
         step(x, 22);
         chk("post_rst_rgb", 32'({red, green, blue}), 32'h0000FF);
         chk("post_rst_de", 32'(de), 32'((x < 256) ? 1 : 0));
      end
      step(62, 23);
      chk("next_base", 32'(vdp_addr), 32'd168);
      step(63, 23);
      chk("next_ld", 32'(vdp_addr), 32'd169);
      step(64, 23);
      chk("next_pix", 32'({red, green, blue}), 32'hFF0000);
      chk("next_de", 32'(de), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
